// File: rtl/hazard_ctl.sv
// Pipeline hazard controller for the five-stage datapath: drives PC / IF/ID / ID/EX / EX/MEM
// enables, flushes and bubbles; zero-cycle latency from hazard, hold and branch to the enables.
// Backpressure: a data-memory wait (mem_req & ~mem_ready) freezes every stage and never consumes a bubble.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ifid_rs, ifid_rt               source registers of the instruction in IF/ID
//   idex_memread, idex_rt          load flag and destination of the instruction in ID/EX
//   branch_taken                   PCSrc from MEM
//   mem_req, mem_ready             data-memory access handshake of EX/MEM
//   pc_we .. exmem_flush           pipeline register controls (combinational)
//   stall_cnt, flush_cnt, state    registered debug observables
module hazard_ctl #(
  parameter int LOAD_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        idex_memread,
  input  logic [4:0]  idex_rt,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_we,
  output logic        idex_bubble,
  output logic        exmem_we,
  output logic        exmem_flush,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    ILLEGAL    = 2'd2,
    MEM_WAIT   = 2'd3
  } state_t;

  localparam logic [1:0] LEFT_INIT = 2'(LOAD_BUBBLES - 1);

  state_t      state_q, state_d, eff_state;
  logic [1:0]  left_q, left_d;
  logic        saved_q, saved_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        hold, hazard, stall_inc, flush_inc;

  assign hold   = mem_req & ~mem_ready;
  assign hazard = idex_memread & (idex_rt != 5'd0) &
                  ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  // Once memory releases, MEM_WAIT acts as whichever state it interrupted.
  assign eff_state = (state_q == MEM_WAIT) ? (saved_q ? LOAD_STALL : RUN) : state_q;

  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_we     = 1'b0;
    idex_bubble = 1'b0;
    exmem_we    = 1'b0;
    exmem_flush = 1'b0;
    state_d     = state_q;
    left_d      = left_q;
    saved_d     = saved_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (rst) begin
      state_d = RUN;
      left_d  = 2'd0;
      saved_d = 1'b0;
    end else if (state_q == ILLEGAL) begin
      // Unused encoding: freeze the pipe for one cycle and return to RUN.
      state_d   = RUN;
      left_d    = 2'd0;
      stall_inc = 1'b1;
    end else if (hold) begin
      // Branch and hazard are re-presented by the frozen EX/MEM, so ignore them here.
      if (state_q != MEM_WAIT) begin
        saved_d = (state_q == LOAD_STALL);
        state_d = MEM_WAIT;
      end
      stall_inc = 1'b1;
    end else if (branch_taken) begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b1;
      idex_we     = 1'b1;
      idex_bubble = 1'b1;
      exmem_we    = 1'b1;
      exmem_flush = 1'b1;
      left_d      = 2'd0;
      state_d     = RUN;
      flush_inc   = 1'b1;
    end else if (eff_state == LOAD_STALL || hazard) begin
      idex_we     = 1'b1;
      idex_bubble = 1'b1;
      exmem_we    = 1'b1;
      stall_inc   = 1'b1;
      if (eff_state == LOAD_STALL) begin
        // left<=1 also guards against underflow on a corrupted count.
        if (left_q <= 2'd1) begin
          left_d  = 2'd0;
          state_d = RUN;
        end else begin
          left_d  = left_q - 2'd1;
          state_d = LOAD_STALL;
        end
      end else begin
        left_d  = LEFT_INIT;
        state_d = (LOAD_BUBBLES > 1) ? LOAD_STALL : RUN;
      end
    end else begin
      pc_we    = 1'b1;
      ifid_we  = 1'b1;
      idex_we  = 1'b1;
      exmem_we = 1'b1;
      state_d  = RUN;
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rst) begin
      stall_cnt_d = 16'd0;
      flush_cnt_d = 16'd0;
    end else begin
      if (stall_inc && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      if (flush_inc && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      left_q      <= 2'd0;
      saved_q     <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      saved_q     <= saved_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign state     = state_q;

endmodule

// File: doc/hazard_ctl.md
# hazard_ctl

Pipeline hazard controller for the five-stage MIPS datapath. It sequences the IF/ID, ID/EX and EX/MEM pipeline registers and the PC: it freezes them for load-use hazards and data-memory waits, squashes them on a taken branch, and converts ID/EX loads into bubbles. It sits beside the decode stage and drives the write-enable, flush and bubble inputs of the pipeline registers, plus 16-bit stall/flush event counters for debug.

## Interface
- LOAD_BUBBLES, 1: bubbles inserted per load-use hazard; legal range 1..3.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ifid_rs  in  5  rs field (instr[25:21]) of the instruction in IF/ID.
- ifid_rt  in  5  rt field (instr[20:16]) of the instruction in IF/ID.
- idex_memread  in  1  MemRead bit of the ID/EX M control field.
- idex_rt  in  5  ID/EX instr[20:16] (load destination).
- branch_taken  in  1  PCSrc from the MEM stage.
- mem_req  in  1  EX/MEM holds a load or store.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID write enable.
- ifid_flush  out  1  IF/ID loads zero (nop).
- idex_we  out  1  ID/EX write enable.
- idex_bubble  out  1  ID/EX loads zero WB/M/EX control fields.
- exmem_we  out  1  EX/MEM write enable.
- exmem_flush  out  1  EX/MEM loads zero control fields.
- stall_cnt  out  16  count of cycles with pc_we=0 outside reset, saturating.
- flush_cnt  out  16  count of branch flushes, saturating.
- state  out  2  current FSM state.

## Operation
- States: RUN=0, LOAD_STALL=1, MEM_WAIT=3. Encoding 2 is unused and recovers to RUN on the next edge.
- Internal registers: `left`, 2 bits, remaining bubbles; `saved`, 1 bit, state to resume after MEM_WAIT.
- Definitions:
  - hold = mem_req & ~mem_ready.
  - hazard = idex_memread & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt).
- Priority in every state: rst > hold > branch_taken > bubble (hazard in RUN, or the LOAD_STALL state) > normal.
- rst=1:
  - All write enables are 0. All flush and bubble outputs are 0.
  - Next state is RUN. `left`, `saved`, stall_cnt and flush_cnt are cleared.
- hold:
  - pc_we, ifid_we, idex_we and exmem_we are 0. No flush or bubble.
  - From RUN or LOAD_STALL: saved is set to the current state, next state is MEM_WAIT, and `left` is unchanged.
  - In MEM_WAIT: stay.
  - branch_taken and hazard are ignored, because EX/MEM is frozen and re-presents them.
- MEM_WAIT with hold=0: behave exactly as state `saved` for this cycle, including branch, hazard and bubble evaluation, and take that state's transition.
- branch_taken (no hold):
  - All write enables are 1, and ifid_flush, idex_bubble and exmem_flush are 1.
  - `left` is cleared and the next state is RUN.
  - flush_cnt increments by 1.
- Bubble cycle (no hold, no branch):
  - pc_we=0, ifid_we=0, idex_we=1, idex_bubble=1, exmem_we=1. No flushes.
  - In RUN with hazard: `left` is loaded with LOAD_BUBBLES-1. Next state is LOAD_STALL if LOAD_BUBBLES>1, otherwise RUN.
  - In LOAD_STALL: hazard is not re-evaluated. If left==1, next state is RUN and `left` becomes 0; otherwise `left` decrements.
- Normal cycle: all write enables are 1 and no flushes.
- stall_cnt increments on every non-reset cycle with pc_we=0, i.e. hold cycles and bubble cycles. Both counters saturate at 0xFFFF.

## Timing
- Outputs other than the counters and state are combinational from the current state and same-cycle inputs, so there is zero latency from hazard, hold or branch to the enables.
- state, left, saved, stall_cnt and flush_cnt are registered and update on the rising edge.
- Load-use penalty is exactly LOAD_BUBBLES bubble cycles plus any interleaved hold cycles. A hold never consumes a bubble.
- A branch taken in the same cycle as a hazard or LOAD_STALL cancels the remaining bubbles; the flush occurs that cycle.
- Reset mid-operation (any state) discards pending bubbles and saved state. The first cycle after rst falls is in RUN.

## Test plan
- LOAD_BUBBLES=1; idex_memread=1, idex_rt=8, ifid_rs=8 for one cycle, then idex_memread=0 → cycle 0: pc_we=0, ifid_we=0, idex_bubble=1; cycle 1: all we=1; stall_cnt=1, state stays 0.
- idex_memread=1, idex_rt=0, ifid_rs=0 → no stall, all we=1, stall_cnt=0.
- LOAD_BUBBLES=3, hazard one cycle → three consecutive bubble cycles; state=1 after the 1st and 2nd bubble, 0 after the 3rd; stall_cnt=3.
- LOAD_BUBBLES=3, hazard, then branch_taken=1 on the 2nd bubble cycle → that cycle ifid_flush=idex_bubble=exmem_flush=1 and pc_we=1; next state 0, no 3rd bubble; flush_cnt=1, stall_cnt=1.
- LOAD_BUBBLES=3; after the first bubble (left=2), mem_req=1 and mem_ready=0 for 4 cycles → all we=0 and state=3 for 4 cycles; then 2 more bubble cycles, then RUN; stall_cnt=7.
- In MEM_WAIT with stall_cnt=5, assert rst for one cycle → all enables 0 during reset; next cycle state=0, stall_cnt=0, flush_cnt=0; with mem_req=0, all we=1.
